alu_hazard_ctrl: RTL and testbench

Pipeline controller that sequences the EX-stage ALU operand muxes of the 5-stage MIPS core. It keeps its own shadow copy of the destination-register and control fields of the ID/EX, EX/MEM and MEM/WB stages. From these it produces registered forwarding selects (c_data1_src, c_data2_src) for the instruction entering EX. It also produces load-use stall, flush bubbles and an external-hold freeze, and counts stall cycles for debug.

---
 rtl/alu_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_hazard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_hazard_ctrl.sv
// alu_hazard_ctrl: EX-stage operand forwarding, load-use stall, branch flush
// and external freeze control for a 5-stage MIPS pipeline. It keeps a shadow
// copy of the ID/EX, EX/MEM and MEM/WB destination and control fields.
// The forwarding selects are registered so they line up with the instruction
// as it enters EX. The stall/flush/freeze controls are combinational.
module alu_hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    input  logic             hold,
    output logic [1:0]       c_data1_src,
    output logic [1:0]       c_data2_src,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count,
    // Debug: current FSM state (1 = HOLD) and the MEM/WB shadow {dst, regwrite, memread}.
    output logic             dbg_state,
    output logic [REG_W+1:0] dbg_wb
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;   // EX/MEM result
    localparam logic [1:0] SEL_WB  = 2'b01;   // MEM/WB result

    state_t           state_q, state_d;
    logic [REG_W-1:0] ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
    logic             ex_rw_q, ex_rw_d, mem_rw_q, mem_rw_d, wb_rw_q, wb_rw_d;
    logic             ex_mr_q, ex_mr_d, mem_mr_q, mem_mr_d, wb_mr_q, wb_mr_d;
    logic [1:0]       sel1_q, sel1_d, sel2_q, sel2_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             lu;

    // Forwarding select for one source operand; the younger producer (EX/MEM) wins.
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_W-1:0] r,
                                           input logic [REG_W-1:0] ex_dst, input logic ex_rw,
                                           input logic [REG_W-1:0] mem_dst, input logic mem_rw);
        if (uses && ex_rw && (ex_dst != '0) && (ex_dst == r))
            return SEL_MEM;
        else if (uses && mem_rw && (mem_dst != '0) && (mem_dst == r))
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

    // Load-use hazard: a load in EX produces a register the ID instruction needs now.
    always_comb begin
        lu = ex_mr_q && (ex_dst_q != '0) &&
             ((id_uses_rs && (ex_dst_q == id_rs)) || (id_uses_rt && (ex_dst_q == id_rt)));
    end

    // Pipeline control outputs; a flush outranks a load-use stall, and a flush
    // seen together with hold is dropped because the requester repeats it.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (state_q == ST_HOLD) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (flush && !hold) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Next-state: shadows shift and selects update only in RUN; HOLD freezes all of it.
    always_comb begin
        state_d   = state_q;
        ex_dst_d  = ex_dst_q;
        ex_rw_d   = ex_rw_q;
        ex_mr_d   = ex_mr_q;
        mem_dst_d = mem_dst_q;
        mem_rw_d  = mem_rw_q;
        mem_mr_d  = mem_mr_q;
        wb_dst_d  = wb_dst_q;
        wb_rw_d   = wb_rw_q;
        wb_mr_d   = wb_mr_q;
        sel1_d    = sel1_q;
        sel2_d    = sel2_q;
        stall_d   = stall_q;
        if (state_q == ST_RUN) begin
            wb_dst_d  = mem_dst_q;
            wb_rw_d   = mem_rw_q;
            wb_mr_d   = mem_mr_q;
            mem_dst_d = ex_dst_q;
            mem_rw_d  = ex_rw_q;
            mem_mr_d  = ex_mr_q;
            if (idex_bubble) begin
                ex_dst_d = '0;
                ex_rw_d  = 1'b0;
                ex_mr_d  = 1'b0;
                sel1_d   = SEL_RF;
                sel2_d   = SEL_RF;
            end else begin
                ex_dst_d = id_dst;
                ex_rw_d  = id_regwrite;
                ex_mr_d  = id_memread;
                sel1_d   = fwd_sel(id_uses_rs, id_rs, ex_dst_q, ex_rw_q, mem_dst_q, mem_rw_q);
                sel2_d   = fwd_sel(id_uses_rt, id_rt, ex_dst_q, ex_rw_q, mem_dst_q, mem_rw_q);
            end
        end
        state_d = hold ? ST_HOLD : ST_RUN;
        if (!pc_write && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // State, shadow pipeline, forwarding selects and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            ex_dst_q  <= '0;
            ex_rw_q   <= 1'b0;
            ex_mr_q   <= 1'b0;
            mem_dst_q <= '0;
            mem_rw_q  <= 1'b0;
            mem_mr_q  <= 1'b0;
            wb_dst_q  <= '0;
            wb_rw_q   <= 1'b0;
            wb_mr_q   <= 1'b0;
            sel1_q    <= SEL_RF;
            sel2_q    <= SEL_RF;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            ex_dst_q  <= ex_dst_d;
            ex_rw_q   <= ex_rw_d;
            ex_mr_q   <= ex_mr_d;
            mem_dst_q <= mem_dst_d;
            mem_rw_q  <= mem_rw_d;
            mem_mr_q  <= mem_mr_d;
            wb_dst_q  <= wb_dst_d;
            wb_rw_q   <= wb_rw_d;
            wb_mr_q   <= wb_mr_d;
            sel1_q    <= sel1_d;
            sel2_q    <= sel2_d;
            stall_q   <= stall_d;
        end
    end

    assign c_data1_src = sel1_q;
    assign c_data2_src = sel2_q;
    assign stall_count = stall_q;
    assign dbg_state   = (state_q == ST_HOLD);
    assign dbg_wb      = {wb_dst_q, wb_rw_q, wb_mr_q};

endmodule

// File: tb/tb_alu_hazard_ctrl.sv
// Directed testbench for alu_hazard_ctrl: hand-computed expectations for
// forwarding, load-use stall, flush, hold freeze, counter saturation and reset.
module tb_alu_hazard_ctrl;

    localparam int CNT_W = 16;
    localparam int REG_W = 5;

    logic             clk;
    logic             rst_n;
    logic [REG_W-1:0] id_rs, id_rt, id_dst;
    logic             id_uses_rs, id_uses_rt, id_regwrite, id_memread;
    logic             flush, hold;
    logic [1:0]       c_data1_src, c_data2_src;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [CNT_W-1:0] stall_count;
    logic             dbg_state;
    logic [REG_W+1:0] dbg_wb;

    int n_checks = 0;
    int n_errors = 0;
    logic [CNT_W-1:0] s0;

    alu_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .hold(hold),
        .c_data1_src(c_data1_src), .c_data2_src(c_data2_src),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .stall_count(stall_count),
        .dbg_state(dbg_state), .dbg_wb(dbg_wb)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic set_id(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                          input logic urs, input logic urt, input logic [REG_W-1:0] dst,
                          input logic rw, input logic mr);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dst = dst; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        #3;
        check("rst_sel1", 32'(c_data1_src), 0);
        check("rst_sel2", 32'(c_data2_src), 0);
        check("rst_cnt", 32'(stall_count), 0);
        check("rst_pcw", 32'(pc_write), 1);
        check("rst_ifidw", 32'(ifid_write), 1);
        check("rst_flush", 32'(ifid_flush), 0);
        check("rst_bubble", 32'(idex_bubble), 0);
        check("rst_state", 32'(dbg_state), 0);
        #9 rst_n = 1'b1;
        step();

        // 1: add $8 <- $9+$10 ; sub $11 <- $8-$12 -> 10/00, no stall
        set_id(9, 10, 1, 1, 8, 1, 0);
        step();
        set_id(8, 12, 1, 1, 11, 1, 0);
        #1;
        check("t1_pcw", 32'(pc_write), 1);
        check("t1_bubble", 32'(idex_bubble), 0);
        step();
        check("t1_sel1", 32'(c_data1_src), 32'b10);
        check("t1_sel2", 32'(c_data2_src), 32'b00);

        // 2: add $8 ; unrelated ; and $13 <- $12 & $8 -> 00/01
        set_id(9, 10, 1, 1, 8, 1, 0);
        step();
        set_id(1, 2, 1, 1, 20, 1, 0);
        step();
        set_id(12, 8, 1, 1, 13, 1, 0);
        #1;
        check("t2_pcw", 32'(pc_write), 1);
        step();
        check("t2_sel1", 32'(c_data1_src), 32'b00);
        check("t2_sel2", 32'(c_data2_src), 32'b01);
        check("t2_wb", 32'(dbg_wb), 32'({5'd8, 1'b1, 1'b0}));

        // 3: lw $8,0($9) ; add $10 <- $8+$8 -> one stall cycle, bubble, then 01/01
        s0 = stall_count;
        set_id(9, 0, 1, 0, 8, 1, 1);
        step();
        set_id(8, 8, 1, 1, 10, 1, 0);
        #1;
        check("t3_pcw", 32'(pc_write), 0);
        check("t3_ifidw", 32'(ifid_write), 0);
        check("t3_bubble", 32'(idex_bubble), 1);
        step();
        check("t3_bub_sel1", 32'(c_data1_src), 32'b00);
        check("t3_bub_sel2", 32'(c_data2_src), 32'b00);
        check("t3_cnt", 32'(stall_count), 32'(s0) + 1);
        #1;
        check("t3_pcw2", 32'(pc_write), 1);
        step();
        check("t3_sel1", 32'(c_data1_src), 32'b01);
        check("t3_sel2", 32'(c_data2_src), 32'b01);

        // 4: writer/loader of $0 followed by reader of $0 -> no stall, 00/00
        set_id(0, 0, 0, 0, 0, 1, 1);
        step();
        set_id(0, 0, 1, 1, 5, 1, 0);
        #1;
        check("t4_pcw", 32'(pc_write), 1);
        check("t4_bubble", 32'(idex_bubble), 0);
        step();
        check("t4_sel1", 32'(c_data1_src), 32'b00);
        check("t4_sel2", 32'(c_data2_src), 32'b00);
        step();
        check("t4_sel1_mem", 32'(c_data1_src), 32'b00);
        check("t4_sel2_mem", 32'(c_data2_src), 32'b00);

        // 5: flush together with a load-use hazard -> flush wins, no stall count
        set_id(9, 0, 1, 0, 8, 1, 1);
        step();
        set_id(8, 8, 1, 1, 10, 1, 0);
        flush = 1'b1;
        s0 = stall_count;
        #1;
        check("t5_flush", 32'(ifid_flush), 1);
        check("t5_bubble", 32'(idex_bubble), 1);
        check("t5_pcw", 32'(pc_write), 1);
        check("t5_ifidw", 32'(ifid_write), 1);
        step();
        flush = 1'b0;
        check("t5_cnt", 32'(stall_count), 32'(s0));
        check("t5_sel1", 32'(c_data1_src), 32'b00);
        set_id(0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        // 6: hold for 3 cycles with a forward pending
        set_id(9, 10, 1, 1, 8, 1, 0);
        step();
        set_id(8, 12, 1, 1, 11, 1, 0);
        step();
        check("t6_pre_sel1", 32'(c_data1_src), 32'b10);
        set_id(12, 8, 1, 1, 13, 1, 0);
        hold = 1'b1;
        step();
        s0 = stall_count;
        check("t6_entry_sel1", 32'(c_data1_src), 32'b00);
        check("t6_entry_sel2", 32'(c_data2_src), 32'b01);
        check("t6_state", 32'(dbg_state), 1);
        set_id(11, 11, 1, 1, 14, 1, 0);
        flush = 1'b1;
        #1;
        check("t6_pcw", 32'(pc_write), 0);
        check("t6_ifidw", 32'(ifid_write), 0);
        check("t6_flush_ign", 32'(ifid_flush), 0);
        check("t6_bubble", 32'(idex_bubble), 0);
        step();
        step();
        hold = 1'b0;
        flush = 1'b0;
        set_id(13, 0, 1, 0, 15, 1, 0);
        step();
        check("t6_cnt", 32'(stall_count), 32'(s0) + 3);
        check("t6_hold_sel1", 32'(c_data1_src), 32'b00);
        check("t6_hold_sel2", 32'(c_data2_src), 32'b01);
        check("t6_state_run", 32'(dbg_state), 0);
        #1;
        check("t6_pcw_run", 32'(pc_write), 1);
        step();
        check("t6_after_sel1", 32'(c_data1_src), 32'b10);
        check("t6_after_sel2", 32'(c_data2_src), 32'b00);

        // Saturation through a long hold
        hold = 1'b1;
        step();
        for (int i = 0; i < 65540; i++) step();
        check("sat_cnt", 32'(stall_count), 32'hFFFF);
        step();
        check("sat_nowrap", 32'(stall_count), 32'hFFFF);
        check("sat_state", 32'(dbg_state), 1);

        // Asynchronous reset in the middle of the hold
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(stall_count), 0);
        check("mid_rst_sel1", 32'(c_data1_src), 0);
        check("mid_rst_sel2", 32'(c_data2_src), 0);
        check("mid_rst_pcw", 32'(pc_write), 1);
        check("mid_rst_ifidw", 32'(ifid_write), 1);
        check("mid_rst_bubble", 32'(idex_bubble), 0);
        check("mid_rst_state", 32'(dbg_state), 0);
        hold = 1'b0;
        #3 rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
